// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared source codes and stage-tag type for the RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    localparam logic QUELLE_BEFEHL = 1'b0;
    localparam logic QUELLE_DATEN  = 1'b1;

    typedef struct packed {
        logic gueltig;
        logic quelle;
    } stage_tag_t;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : Core-side request ports and RAM port bundle of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if #(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
);
    localparam int AW = $clog2(WORDS);

    logic                BefehlAnfrage;
    logic [AW-1:0]       BefehlAdresse;
    logic                BefehlBereit;
    logic                BefehlGueltig;
    logic [WORDSIZE-1:0] BefehlDaten;

    logic                DatenAnfrage;
    logic                DatenSchreiben;
    logic [AW-1:0]       DatenAdresse;
    logic [WORDSIZE-1:0] DatenSchreibwert;
    logic                DatenBereit;
    logic                DatenGueltig;
    logic [WORDSIZE-1:0] DatenLesewert;

    logic                RamSchreibenAn;
    logic [WORDSIZE-1:0] RamDatenRein;
    logic [AW-1:0]       RamAdresse;
    logic [WORDSIZE-1:0] RamDatenRaus;

    modport slave (
        input  BefehlAnfrage, BefehlAdresse,
        output BefehlBereit, BefehlGueltig, BefehlDaten,
        input  DatenAnfrage, DatenSchreiben, DatenAdresse, DatenSchreibwert,
        output DatenBereit, DatenGueltig, DatenLesewert,
        output RamSchreibenAn, RamDatenRein, RamAdresse,
        input  RamDatenRaus
    );

    modport master (
        output BefehlAnfrage, BefehlAdresse,
        input  BefehlBereit, BefehlGueltig, BefehlDaten,
        output DatenAnfrage, DatenSchreiben, DatenAdresse, DatenSchreibwert,
        input  DatenBereit, DatenGueltig, DatenLesewert,
        input  RamSchreibenAn, RamDatenRein, RamAdresse,
        output RamDatenRaus
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
//  Module      : rr_arbiter_2
//  Description : Two-way round-robin arbiter with one-hot grants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire logic [1:0] req_i,      // [0] = Befehl, [1] = Daten
    input  wire logic       accept_i,
    output logic      [1:0] gnt_o
);

    // ptr_q = 0: Daten wins a tie; ptr_q = 1: Befehl wins a tie.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o[1] = req_i[1] & (~req_i[0] | ~ptr_q);
        gnt_o[0] = req_i[0] & (~req_i[1] |  ptr_q);
        ptr_d    = accept_i ? gnt_o[1] : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one synchronous RAM between fetch and load/store ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
) (
    input  wire logic      Clock,
    input  wire logic      Reset_n,
    ram_arbiter_if.slave   bus
);

    localparam int AW = $clog2(WORDS);

    logic [1:0]          w_req;
    logic [1:0]          w_gnt_raw;
    logic [1:0]          w_gnt;
    logic                w_accept;

    stage_tag_t          tag_q;
    stage_tag_t          tag_d;
    logic                befehl_gueltig_q;
    logic [WORDSIZE-1:0] befehl_daten_q;
    logic                daten_gueltig_q;
    logic [WORDSIZE-1:0] daten_lesewert_q;

    assign w_req = {bus.DatenAnfrage, bus.BefehlAnfrage};

    rr_arbiter_2 u_rr (
        .clk_i    (Clock),
        .rst_ni   (Reset_n),
        .req_i    (w_req),
        .accept_i (w_accept),
        .gnt_o    (w_gnt_raw)
    );

    assign w_accept = |w_gnt_raw;

    // Outputs are blanked during reset so no RAM write can slip through an edge.
    assign w_gnt = w_gnt_raw & {2{Reset_n}};

    assign bus.BefehlBereit = w_gnt[0];
    assign bus.DatenBereit  = w_gnt[1];

    always_comb begin
        bus.RamSchreibenAn = 1'b0;
        bus.RamAdresse     = '0;
        bus.RamDatenRein   = '0;
        if (w_gnt[1]) begin
            bus.RamSchreibenAn = bus.DatenSchreiben;
            bus.RamAdresse     = bus.DatenAdresse;
            bus.RamDatenRein   = bus.DatenSchreibwert;
        end else if (w_gnt[0]) begin
            bus.RamAdresse     = bus.BefehlAdresse;
        end
    end

    always_comb begin
        tag_d.gueltig = w_gnt_raw[0] | (w_gnt_raw[1] & ~bus.DatenSchreiben);
        tag_d.quelle  = w_gnt_raw[1] ? QUELLE_DATEN : QUELLE_BEFEHL;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tag_q            <= '0;
            befehl_gueltig_q <= 1'b0;
            befehl_daten_q   <= '0;
            daten_gueltig_q  <= 1'b0;
            daten_lesewert_q <= '0;
        end else begin
            tag_q            <= tag_d;
            befehl_gueltig_q <= tag_q.gueltig && (tag_q.quelle == QUELLE_BEFEHL);
            daten_gueltig_q  <= tag_q.gueltig && (tag_q.quelle == QUELLE_DATEN);
            if (tag_q.gueltig && (tag_q.quelle == QUELLE_BEFEHL)) begin
                befehl_daten_q <= bus.RamDatenRaus;
            end
            if (tag_q.gueltig && (tag_q.quelle == QUELLE_DATEN)) begin
                daten_lesewert_q <= bus.RamDatenRaus;
            end
        end
    end

    assign bus.BefehlGueltig = befehl_gueltig_q;
    assign bus.BefehlDaten   = befehl_daten_q;
    assign bus.DatenGueltig  = daten_gueltig_q;
    assign bus.DatenLesewert = daten_lesewert_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed vector bench for ram_arbiter with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic loaded  = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    logic [31:0] mem [0:255];

    typedef struct {
        logic        rst;
        logic        breq;
        logic [7:0]  ba;
        logic        dreq;
        logic        dwe;
        logic [7:0]  da;
        logic [31:0] dw;
        logic        ebr;
        logic        edr;
        logic        ebv;
        logic [31:0] ebd;
        logic        edv;
        logic [31:0] edd;
        logic        ewe;
        logic [7:0]  ea;
        logic [31:0] edin;
    } vec_t;

    vec_t vq[$];

    ram_arbiter_if #(.WORDSIZE(32), .WORDS(256)) bus ();

    ram_arbiter #(.WORDSIZE(32), .WORDS(256)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Registered-output RAM; preloaded on the first edge with C0DE00xx, word 5 special.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'hC0DE_0000 | i;
            end
            mem[5] <= 32'hA5A5_0001;
            loaded <= 1'b1;
        end else begin
            if (bus.RamSchreibenAn) mem[bus.RamAdresse] <= bus.RamDatenRein;
            bus.RamDatenRaus <= mem[bus.RamAdresse];
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic breq, input logic [7:0] ba,
                       input logic dreq, input logic dwe, input logic [7:0] da, input logic [31:0] dw,
                       input logic ebr, input logic edr, input logic ebv, input logic [31:0] ebd,
                       input logic edv, input logic [31:0] edd,
                       input logic ewe, input logic [7:0] ea, input logic [31:0] edin);
        vec_t v;
        v.rst = rst; v.breq = breq; v.ba = ba; v.dreq = dreq; v.dwe = dwe; v.da = da; v.dw = dw;
        v.ebr = ebr; v.edr = edr; v.ebv = ebv; v.ebd = ebd; v.edv = edv; v.edd = edd;
        v.ewe = ewe; v.ea = ea; v.edin = edin;
        vq.push_back(v);
    endtask

    task automatic drive(input logic breq, input logic [7:0] ba, input logic dreq,
                         input logic dwe, input logic [7:0] da, input logic [31:0] dw);
        bus.BefehlAnfrage    = breq;
        bus.BefehlAdresse    = ba;
        bus.DatenAnfrage     = dreq;
        bus.DatenSchreiben   = dwe;
        bus.DatenAdresse     = da;
        bus.DatenSchreibwert = dw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic got;

        drive(0, 0, 0, 0, 0, 0);

        //  rst breq ba   dreq dwe da   dw            | ebr edr ebv ebd           edv edd           we ea   din
        add(0, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(0, 1, 3,   1, 1, 9,   32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(0, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   1, 1, 10,  32'h1234_5678, 0, 1, 0, 32'h0,         0, 32'h0,         1, 10,  32'h1234_5678);
        add(1, 0, 0,   1, 0, 10,  32'h0,         0, 1, 0, 32'h0,         0, 32'h0,         0, 10,  32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         1, 32'h1234_5678, 0, 0,   32'h0);
        add(1, 1, 5,   0, 0, 0,   32'h0,         1, 0, 0, 32'h0,         0, 32'h1234_5678, 0, 5,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h1234_5678, 0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 1, 32'hA5A5_0001, 0, 32'h1234_5678, 0, 0,   32'h0);
        // contention: D,B,D,B,D,B
        add(1, 1, 0,   1, 0, 100, 32'h0,         0, 1, 0, 32'hA5A5_0001, 0, 32'h1234_5678, 0, 100, 32'h0);
        add(1, 1, 0,   1, 0, 101, 32'h0,         1, 0, 0, 32'hA5A5_0001, 0, 32'h1234_5678, 0, 0,   32'h0);
        add(1, 1, 1,   1, 0, 101, 32'h0,         0, 1, 0, 32'hA5A5_0001, 1, 32'hC0DE_0064, 0, 101, 32'h0);
        add(1, 1, 1,   1, 0, 102, 32'h0,         1, 0, 1, 32'hC0DE_0000, 0, 32'hC0DE_0064, 0, 1,   32'h0);
        add(1, 1, 2,   1, 0, 102, 32'h0,         0, 1, 0, 32'hC0DE_0000, 1, 32'hC0DE_0065, 0, 102, 32'h0);
        add(1, 1, 2,   0, 0, 0,   32'h0,         1, 0, 1, 32'hC0DE_0001, 0, 32'hC0DE_0065, 0, 2,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'hC0DE_0001, 1, 32'hC0DE_0066, 0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 1, 32'hC0DE_0002, 0, 32'hC0DE_0066, 0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'hC0DE_0002, 0, 32'hC0DE_0066, 0, 0,   32'h0);
        // back-to-back fetches 0..3
        add(1, 1, 0,   0, 0, 0,   32'h0,         1, 0, 0, 32'hC0DE_0002, 0, 32'hC0DE_0066, 0, 0,   32'h0);
        add(1, 1, 1,   0, 0, 0,   32'h0,         1, 0, 0, 32'hC0DE_0002, 0, 32'hC0DE_0066, 0, 1,   32'h0);
        add(1, 1, 2,   0, 0, 0,   32'h0,         1, 0, 1, 32'hC0DE_0000, 0, 32'hC0DE_0066, 0, 2,   32'h0);
        add(1, 1, 3,   0, 0, 0,   32'h0,         1, 0, 1, 32'hC0DE_0001, 0, 32'hC0DE_0066, 0, 3,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 1, 32'hC0DE_0002, 0, 32'hC0DE_0066, 0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 1, 32'hC0DE_0003, 0, 32'hC0DE_0066, 0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'hC0DE_0003, 0, 32'hC0DE_0066, 0, 0,   32'h0);
        // reset with a load in flight
        add(1, 0, 0,   1, 0, 7,   32'h0,         0, 1, 0, 32'hC0DE_0003, 0, 32'hC0DE_0066, 0, 7,   32'h0);
        add(0, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(0, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   1, 0, 7,   32'h0,         0, 1, 0, 32'h0,         0, 32'h0,         0, 7,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 0,   32'h0);
        add(1, 0, 0,   0, 0, 0,   32'h0,         0, 0, 0, 32'h0,         1, 32'hC0DE_0007, 0, 0,   32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n = vq[i].rst;
            drive(vq[i].breq, vq[i].ba, vq[i].dreq, vq[i].dwe, vq[i].da, vq[i].dw);
            @(negedge clk);
            check("BefehlBereit",   i, {31'b0, bus.BefehlBereit},   {31'b0, vq[i].ebr});
            check("DatenBereit",    i, {31'b0, bus.DatenBereit},    {31'b0, vq[i].edr});
            check("BefehlGueltig",  i, {31'b0, bus.BefehlGueltig},  {31'b0, vq[i].ebv});
            check("BefehlDaten",    i, bus.BefehlDaten,             vq[i].ebd);
            check("DatenGueltig",   i, {31'b0, bus.DatenGueltig},   {31'b0, vq[i].edv});
            check("DatenLesewert",  i, bus.DatenLesewert,           vq[i].edd);
            check("RamSchreibenAn", i, {31'b0, bus.RamSchreibenAn}, {31'b0, vq[i].ewe});
            check("RamAdresse",     i, {24'b0, bus.RamAdresse},     {24'b0, vq[i].ea});
            check("RamDatenRein",   i, bus.RamDatenRein,            vq[i].edin);
        end

        // Tie with Befehl priority: fetch of 20 precedes store to 20, refetch sees the store.
        @(posedge clk); #1;
        drive(1, 20, 1, 1, 20, 32'hDEAD_BEEF);
        @(negedge clk);
        check("seq_tie_bgnt", 0, {31'b0, bus.BefehlBereit}, 32'd1);
        check("seq_tie_dgnt", 0, {31'b0, bus.DatenBereit},  32'd0);
        @(posedge clk); #1;
        bus.BefehlAnfrage = 1'b0;
        @(negedge clk);
        check("seq_store_gnt",  1, {31'b0, bus.DatenBereit},    32'd1);
        check("seq_store_we",   1, {31'b0, bus.RamSchreibenAn}, 32'd1);
        check("seq_store_data", 1, bus.RamDatenRein,            32'hDEAD_BEEF);
        @(posedge clk); #1;
        drive(1, 20, 0, 0, 0, 0);
        @(negedge clk);
        check("seq_old_valid", 2, {31'b0, bus.BefehlGueltig}, 32'd1);
        check("seq_old_data",  2, bus.BefehlDaten,            32'hC0DE_0014);
        check("seq_refetch",   2, {31'b0, bus.BefehlBereit},  32'd1);
        @(posedge clk); #1;
        bus.BefehlAnfrage = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (k == 1) check("seq_store_noval", 3, {31'b0, bus.DatenGueltig}, 32'd0);
            if (bus.BefehlGueltig) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("seq_new_latency", 4, lat, 32'd2);
        check("seq_new_data",    4, bus.BefehlDaten, 32'hDEAD_BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous RAM between the instruction-fetch unit and the load/store unit.
- Grants at most one requester per cycle using 2-way round-robin, drives the RAM port, and returns read data through a registered response stage.
- Sits between the processor core and the RAM: one RAM instance, two core-side request ports.

Parameters:
- WORDSIZE, 32, data word width in bits; must match the RAM.
- WORDS, 256, RAM depth; address width AW = $clog2(WORDS).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- BefehlAnfrage  in  1  fetch read request.
- BefehlAdresse  in  AW  fetch word address.
- BefehlBereit  out  1  fetch request accepted this cycle.
- BefehlGueltig  out  1  BefehlDaten valid this cycle.
- BefehlDaten  out  WORDSIZE  fetched word.
- DatenAnfrage  in  1  load/store request.
- DatenSchreiben  in  1  1 = store, 0 = load.
- DatenAdresse  in  AW  load/store word address.
- DatenSchreibwert  in  WORDSIZE  store data.
- DatenBereit  out  1  load/store request accepted this cycle.
- DatenGueltig  out  1  DatenLesewert valid this cycle (loads only).
- DatenLesewert  out  WORDSIZE  loaded word.
- RamSchreibenAn  out  1  to RAM write enable.
- RamDatenRein  out  WORDSIZE  to RAM write data.
- RamAdresse  out  AW  to RAM address.
- RamDatenRaus  in  WORDSIZE  from RAM registered read data.

Behaviour:
- Reset (Reset_n low, async): BefehlGueltig, DatenGueltig, BefehlDaten, DatenLesewert, stage-1 tag and round-robin pointer all clear to 0. Pointer 0 means Daten wins the next tie.
- While Reset_n is low, Bereit and RamSchreibenAn are forced to 0 combinationally, so no RAM write can occur at an edge during reset.
- Handshake:
  - A requester holds Anfrage, address, Schreiben and Schreibwert stable until it samples Bereit=1.
  - Accept = Anfrage & Bereit in the same cycle.
  - Bereit is combinational from the requests and the pointer; it never depends on Gueltig.
- Arbitration:
  - Only one requester requesting: it is granted.
  - Both requesting: the one not granted last time wins. The pointer updates on every accept.
  - Maximum wait for any requester is 1 cycle.
  - BefehlBereit and DatenBereit are never high together.
- RAM drive in the accept cycle: the winner's address, write data and write enable are routed to the RAM combinationally; RamSchreibenAn = DatenSchreiben only for a Daten grant.
- Idle cycle: RamSchreibenAn=0, RamAdresse=0, RamDatenRein=0.
- Pipeline (fully pipelined, one accept per cycle possible):
  - Cycle N: accept; RAM samples at edge N+1.
  - Stage-1 tag {gueltig, quelle} is registered at edge N+1, set only for reads.
  - Cycle N+1: RamDatenRaus holds the read word.
  - Edge N+2: the word is captured into BefehlDaten or DatenLesewert per tag.
  - Cycle N+2: matching Gueltig high for exactly one cycle.
  - Read latency = 2 cycles from accept.
- Stores: take effect at edge N+1, produce no Gueltig pulse, and do not disturb the output registers.
- Ordering: RAM accesses execute in accept order. A load accepted the cycle after a store to the same address returns the new value.
- Output registers hold their last value when Gueltig=0.
- Reset mid-operation: in-flight read tags are discarded, so no Gueltig after release. The first cycle after release arbitrates normally.

Decomposition:
- Shared package ram_arbiter_pkg:
  - QUELLE_BEFEHL = 1'b0, QUELLE_DATEN = 1'b1.
  - Stage-tag typedef {gueltig, quelle}.
- One natural sub-module: rr_arbiter_2. It takes two requests, the accept signal and the pointer register, and produces one-hot grants. It owns the reset of the pointer.

Test Plan:
- Reset then idle: Reset_n=0 for 3 cycles, then release with no requests. All outputs 0; RamSchreibenAn=0 on every cycle.
- Single fetch: RAM preloaded word 5 = 32'hA5A5_0001; BefehlAnfrage, address 5. BefehlBereit in cycle 0; BefehlGueltig only in cycle 2 with BefehlDaten = 32'hA5A5_0001; DatenGueltig stays 0.
- Store then load: store 32'h1234_5678 to address 10, then load address 10 in the next cycle. RAM written at edge 1; DatenGueltig in cycle 3 with 32'h1234_5678; no Gueltig pulse for the store.
- Contention:
  - Both ports request continuously for 6 cycles (fetch addr 0..2, loads addr 100..102).
  - Grants alternate D,B,D,B,D,B and are never simultaneous.
  - Each Gueltig appears 2 cycles after its accept with the correct word.
- Back-to-back pipelining: 4 fetches on consecutive cycles, addresses 0..3. BefehlGueltig is high for 4 consecutive cycles, starting 2 cycles after the first accept, with data in address order.
- Reset mid-flight: accept a load to address 7, then Reset_n=0 in cycle 1 and release in cycle 3. DatenGueltig never asserts; DatenLesewert=0; the next request is served normally.
